// File: rtl/lsu_mem_stage.sv
// Memory-stage load/store unit: runs one transaction on a variable-latency word bus
// and returns aligned, extended load data, stalling the pipeline while the bus is busy.
module lsu_mem_stage #(
  parameter int MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_readM,
  input  logic        mem_writeM,
  input  logic [2:0]  mem_sizeM,
  input  logic [31:0] alu_outM,
  input  logic [31:0] write_dataM,
  output logic [31:0] read_dataM,
  output logic        stallM,
  output logic        faultM,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam int CW = 10;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          req_q, req_d;
  logic          we_q, we_d;
  logic [31:0]   addr_q, addr_d;
  logic [3:0]    be_q, be_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          fault_q, fault_d;
  logic [2:0]    size_q, size_d;
  logic [1:0]    off_q, off_d;

  logic        acc, illegal, misaligned, ok;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [31:0] rd_shift, rd_fmt;

  assign acc     = mem_readM | mem_writeM;
  assign illegal = (mem_readM & mem_writeM)
                 | (mem_sizeM == 3'b011) | (mem_sizeM == 3'b110) | (mem_sizeM == 3'b111)
                 | (mem_writeM & mem_sizeM[2]);
  assign misaligned = ((mem_sizeM[1:0] == 2'b01) & alu_outM[0])
                    | ((mem_sizeM[1:0] == 2'b10) & (alu_outM[1:0] != 2'b00));
  assign ok = ~illegal & ~misaligned;

  // Per-lane store byte enables.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign st_be[gi] = (mem_sizeM[1:0] == 2'b00) ? (alu_outM[1:0] == 2'(gi)) :
                       (mem_sizeM[1:0] == 2'b01) ? (alu_outM[1] == (gi >= 2)) : 1'b1;
  end

  always_comb begin
    st_wdata = write_dataM;
    case (mem_sizeM[1:0])
      2'b00:   st_wdata = {4{write_dataM[7:0]}};
      2'b01:   st_wdata = {2{write_dataM[15:0]}};
      default: st_wdata = write_dataM;
    endcase
  end

  // Load formatting uses the size and byte offset captured when the access started.
  always_comb begin
    rd_shift = bus_rdata >> {off_q, 3'b000};
    rd_fmt   = bus_rdata;
    case (size_q)
      3'b000:  rd_fmt = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'b001:  rd_fmt = {{16{rd_shift[15]}}, rd_shift[15:0]};
      3'b100:  rd_fmt = {24'h0, rd_shift[7:0]};
      3'b101:  rd_fmt = {16'h0, rd_shift[15:0]};
      default: rd_fmt = bus_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    fault_d = 1'b0;
    size_d  = size_q;
    off_d   = off_q;
    case (state_q)
      S_IDLE: begin
        if (acc && ok) begin
          req_d   = 1'b1;
          we_d    = mem_writeM;
          addr_d  = {alu_outM[31:2], 2'b00};
          be_d    = mem_writeM ? st_be : 4'hF;
          wdata_d = mem_writeM ? st_wdata : 32'h0;
          size_d  = mem_sizeM;
          off_d   = alu_outM[1:0];
          cnt_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + CW'(1);
        if (bus_ack) begin
          req_d   = 1'b0;
          if (!we_q) rdata_d = rd_fmt;
          state_d = S_DONE;
        end else if (cnt_d == CW'(MAX_WAIT)) begin
          req_d   = 1'b0;
          fault_d = 1'b1;
          if (!we_q) rdata_d = 32'h0;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      be_q    <= 4'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      fault_q <= 1'b0;
      size_q  <= 3'b000;
      off_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      fault_q <= fault_d;
      size_q  <= size_d;
      off_q   <= off_d;
    end
  end

  // Rejected accesses fault immediately in IDLE; timeouts fault in DONE.
  assign faultM     = fault_q | ((state_q == S_IDLE) & acc & ~ok);
  assign stallM     = acc & ok & (state_q != S_DONE);
  assign read_dataM = rdata_q;
  assign bus_req    = req_q;
  assign bus_we     = we_q;
  assign bus_addr   = addr_q;
  assign bus_be     = be_q;
  assign bus_wdata  = wdata_q;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed bench for lsu_mem_stage: a default-timeout instance plus a MAX_WAIT=4 instance
// for the timeout case.
module tb_lsu_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_readM, mem_writeM;
  logic [2:0]  mem_sizeM;
  logic [31:0] alu_outM, write_dataM;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic [31:0] read_dataM, bus_addr, bus_wdata;
  logic        stallM, faultM, bus_req, bus_we;
  logic [3:0]  bus_be;

  logic        t_read, t_ack;
  logic [31:0] t_rdata;
  logic [31:0] t_read_data, t_bus_addr, t_bus_wdata;
  logic        t_stall, t_fault, t_bus_req, t_bus_we;
  logic [3:0]  t_bus_be;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lsu_mem_stage dut (
    .clk(clk), .reset(reset), .mem_readM(mem_readM), .mem_writeM(mem_writeM),
    .mem_sizeM(mem_sizeM), .alu_outM(alu_outM), .write_dataM(write_dataM),
    .read_dataM(read_dataM), .stallM(stallM), .faultM(faultM), .bus_req(bus_req),
    .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  lsu_mem_stage #(.MAX_WAIT(4)) dut_t (
    .clk(clk), .reset(reset), .mem_readM(t_read), .mem_writeM(1'b0),
    .mem_sizeM(3'b010), .alu_outM(32'h0000_5000), .write_dataM(32'h0),
    .read_dataM(t_read_data), .stallM(t_stall), .faultM(t_fault), .bus_req(t_bus_req),
    .bus_we(t_bus_we), .bus_addr(t_bus_addr), .bus_be(t_bus_be), .bus_wdata(t_bus_wdata),
    .bus_ack(t_ack), .bus_rdata(t_rdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  // Advance to the next cycle; inputs are driven 1ns after the edge, checks at negedge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic access(input logic rd, input logic wr, input logic [2:0] sz,
                        input logic [31:0] addr, input logic [31:0] wd);
    mem_readM = rd; mem_writeM = wr; mem_sizeM = sz; alu_outM = addr; write_dataM = wd;
  endtask

  initial begin
    int stalls;
    reset = 1'b1; access(0, 0, 3'b000, 32'h0, 32'h0);
    bus_ack = 0; bus_rdata = 32'h0; t_read = 0; t_ack = 0; t_rdata = 32'h0;
    repeat (2) next_cycle();
    reset = 1'b0;
    @(negedge clk);
    check("rst_read_data", read_dataM, 32'h0);
    check("rst_bus_req", {31'h0, bus_req}, 32'h0);
    check("rst_bus_be", {28'h0, bus_be}, 32'h0);
    check("rst_stall_fault", {30'h0, stallM, faultM}, 32'h0);
    next_cycle();

    // LB at 0x1003, ack in cycle 1
    access(1, 0, 3'b000, 32'h0000_1003, 32'h0);
    @(negedge clk);
    check("lb_c0_stall_req", {30'h0, stallM, bus_req}, 32'h2);
    next_cycle();
    bus_ack = 1; bus_rdata = 32'h80FF_1234;
    @(negedge clk);
    check("lb_c1_stall_req", {30'h0, stallM, bus_req}, 32'h3);
    check("lb_bus_addr", bus_addr, 32'h0000_1000);
    check("lb_be_we", {27'h0, bus_be, bus_we}, {27'h0, 4'hF, 1'b0});
    next_cycle();
    bus_ack = 0;
    @(negedge clk);
    check("lb_read_data", read_dataM, 32'hFFFF_FF80);
    check("lb_c2_stall_req_fault", {29'h0, stallM, bus_req, faultM}, 32'h0);
    next_cycle();
    access(0, 0, 3'b000, 32'h0, 32'h0);

    // LHU at 0x2002, ack on the 5th wait cycle: 6 stall cycles
    access(1, 0, 3'b101, 32'h0000_2002, 32'h0);
    stalls = 0;
    for (int k = 0; k < 8; k++) begin
      bus_ack = (k == 5); bus_rdata = 32'hBEEF_0000;
      @(negedge clk);
      if (stallM) stalls++;
      if (k == 6) check("lhu_read_data", read_dataM, 32'h0000_BEEF);
      next_cycle();
      if (k == 6) access(0, 0, 3'b000, 32'h0, 32'h0);
    end
    bus_ack = 0;
    check("lhu_stall_cycles", stalls, 32'd6);

    // SB 0xAB at 0x3001
    access(0, 1, 3'b000, 32'h0000_3001, 32'h0000_00AB);
    next_cycle();
    bus_ack = 1;
    @(negedge clk);
    check("sb_we_be", {27'h0, bus_be, bus_we}, {27'h0, 4'b0010, 1'b1});
    check("sb_wdata", bus_wdata, 32'hABAB_ABAB);
    check("sb_addr", bus_addr, 32'h0000_3000);
    next_cycle();
    bus_ack = 0;
    @(negedge clk);
    check("sb_read_data_kept", read_dataM, 32'h0000_BEEF);
    next_cycle();

    // SH at 0x3002 upper half
    access(0, 1, 3'b001, 32'h0000_3002, 32'h0000_1234);
    next_cycle();
    bus_ack = 1;
    @(negedge clk);
    check("sh_be_wdata", {bus_be, bus_wdata[27:0]}, {4'b1100, 28'h2341234});
    next_cycle();
    bus_ack = 0;
    next_cycle();

    // Faulting accesses: misaligned LW, size 011, both strobes
    access(1, 0, 3'b010, 32'h0000_4002, 32'h0);
    @(negedge clk);
    check("lw_mis_fault_stall_req", {29'h0, faultM, stallM, bus_req}, 32'h4);
    next_cycle();
    access(0, 0, 3'b000, 32'h0, 32'h0);
    @(negedge clk);
    check("lw_mis_fault_gone", {31'h0, faultM}, 32'h0);
    next_cycle();
    access(1, 0, 3'b011, 32'h0000_4000, 32'h0);
    @(negedge clk);
    check("sz011_fault_stall_req", {29'h0, faultM, stallM, bus_req}, 32'h4);
    next_cycle();
    access(1, 1, 3'b010, 32'h0000_4000, 32'h0);
    @(negedge clk);
    check("both_fault_stall_req", {29'h0, faultM, stallM, bus_req}, 32'h4);
    next_cycle();
    access(0, 0, 3'b000, 32'h0, 32'h0);
    @(negedge clk);
    check("fault_read_data_kept", read_dataM, 32'h0000_BEEF);
    next_cycle();

    // Timeout instance: prime read data with a good load, then a load that never gets ack
    t_read = 1;
    next_cycle();
    t_ack = 1; t_rdata = 32'h1234_5678;
    next_cycle();
    t_ack = 0;
    @(negedge clk);
    check("to_prime_read_data", t_read_data, 32'h1234_5678);
    next_cycle();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k == 4) check("to_req_last_wait", {31'h0, t_bus_req}, 32'h1);
      next_cycle();
    end
    @(negedge clk);
    check("to_done_req_fault_stall", {29'h0, t_bus_req, t_fault, t_stall}, 32'h2);
    check("to_read_data_zero", t_read_data, 32'h0);
    next_cycle();
    t_read = 0;
    @(negedge clk);
    check("to_fault_one_cycle", {31'h0, t_fault}, 32'h0);
    next_cycle();

    // Reset in the 2nd WAIT cycle, late ack afterwards
    access(1, 0, 3'b010, 32'h0000_6000, 32'h0);
    next_cycle();
    next_cycle();
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid_req_before", {31'h0, bus_req}, 32'h1);
    next_cycle();
    reset = 1'b0; bus_ack = 1; bus_rdata = 32'hDEAD_BEEF;
    access(0, 0, 3'b000, 32'h0, 32'h0);
    @(negedge clk);
    check("rst_mid_req", {29'h0, bus_req, bus_we, faultM}, 32'h0);
    check("rst_mid_addr", bus_addr, 32'h0);
    check("rst_mid_be_wdata", {bus_be, bus_wdata[27:0]}, 32'h0);
    check("rst_mid_read_data", read_dataM, 32'h0);
    next_cycle();
    bus_ack = 0;
    @(negedge clk);
    check("late_ack_ignored", read_dataM, 32'h0);
    check("late_ack_req_stall", {30'h0, bus_req, stallM}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
